// File: rtl/device_io_arbiter.sv
// Two-requester (CPU / debug) arbiter in front of a single device I/O bus.
// One access in flight, fair tie-break, address window check, fixed read latency.
module device_io_arbiter #(
  parameter int unsigned READ_LAT  = 1,
  parameter logic [23:0] BASE_ADDR = 24'h0
) (
  input  logic        clk,
  input  logic        rst_sync_low,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_wen,
  output logic        m0_gnt,
  output logic        m0_done,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_wen,
  output logic        m1_gnt,
  output logic        m1_done,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic [31:0] device_io_addr,
  output logic [31:0] device_io_write_data,
  output logic        device_io_wen,
  input  logic [31:0] device_io_read_data,
  output logic        busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;
  localparam logic [3:0] LAT_LOAD = 4'(READ_LAT - 1);

  logic [1:0]  r_state;
  logic        r_last_gnt;
  logic        r_win;
  logic        r_wen;
  logic        r_err_flag;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_cnt;
  logic [1:0]  r_gnt;
  logic [1:0]  r_done;
  logic [1:0]  r_err;
  logic [31:0] r_rdata [2];
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic        r_bus_wen;

  logic [1:0]  w_req;
  logic [1:0]  w_wen;
  logic [31:0] w_addr [2];
  logic [31:0] w_wdata [2];
  logic        w_pick;

  assign w_req      = {m1_req, m0_req};
  assign w_wen      = {m1_wen, m0_wen};
  assign w_addr[0]  = m0_addr;
  assign w_addr[1]  = m1_addr;
  assign w_wdata[0] = m0_wdata;
  assign w_wdata[1] = m1_wdata;

  // On a tie the requester that did not win last time goes next.
  assign w_pick = (w_req == 2'b11) ? ~r_last_gnt : w_req[1];

  always_ff @(posedge clk) begin
    if (!rst_sync_low) begin
      r_state     <= IDLE;
      r_last_gnt  <= 1'b1;
      r_win       <= 1'b0;
      r_wen       <= 1'b0;
      r_err_flag  <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_done      <= '0;
      r_err       <= '0;
      r_rdata[0]  <= '0;
      r_rdata[1]  <= '0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_wen   <= 1'b0;
    end else begin
      r_gnt  <= '0;
      r_done <= '0;
      r_err  <= '0;
      case (r_state)
        IDLE: begin
          r_bus_addr  <= '0;
          r_bus_wdata <= '0;
          r_bus_wen   <= 1'b0;
          if (|w_req) begin
            r_win         <= w_pick;
            r_last_gnt    <= w_pick;
            r_addr        <= w_addr[w_pick];
            r_wdata       <= w_wdata[w_pick];
            r_wen         <= w_wen[w_pick];
            r_err_flag    <= (w_addr[w_pick][31:8] != BASE_ADDR);
            r_gnt[w_pick] <= 1'b1;
            r_state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (r_err_flag) begin
            r_state <= RESP;
          end else begin
            r_bus_addr  <= r_addr;
            r_bus_wdata <= r_wdata;
            r_bus_wen   <= r_wen;
            if (r_wen) begin
              r_state <= RESP;
            end else begin
              r_cnt   <= LAT_LOAD;
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          r_bus_wdata <= '0;
          r_bus_wen   <= 1'b0;
          if (r_cnt == 4'd0) begin
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          // Bus registers lag the state by one cycle, so read data is valid now.
          r_bus_addr   <= '0;
          r_bus_wdata  <= '0;
          r_bus_wen    <= 1'b0;
          r_done[r_win] <= 1'b1;
          r_err[r_win]  <= r_err_flag;
          if (r_err_flag) begin
            r_rdata[r_win] <= '0;
          end else if (!r_wen) begin
            r_rdata[r_win] <= device_io_read_data;
          end
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign m0_gnt               = r_gnt[0];
  assign m1_gnt               = r_gnt[1];
  assign m0_done              = r_done[0];
  assign m1_done              = r_done[1];
  assign m0_err               = r_err[0];
  assign m1_err               = r_err[1];
  assign m0_rdata             = r_rdata[0];
  assign m1_rdata             = r_rdata[1];
  assign device_io_addr       = r_bus_addr;
  assign device_io_write_data = r_bus_wdata;
  assign device_io_wen        = r_bus_wen;
  assign busy                 = (r_state != IDLE);

endmodule
